adder_arbiter: RTL

Shares the single 32-bit combinational `ADDER` datapath of the MIPS core between several requesters (PC+4, branch target, load/store address calc, ALU). Round-robin arbitration chooses one requester per cycle. The winner's operands are registered into the adder inputs, and the sum is returned one cycle later, tagged with the requester id. The block is fully pipelined at one operation per cycle and has a global stall input.

---
 rtl/mips_pkg.sv | 11 +
 rtl/ADDER.sv | 8 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/adder_arbiter.sv | 81 ++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared core constants: requester count, id width, word width and requester ids.
package mips_pkg;
  localparam int NREQ   = 4;
  localparam int IDW    = $clog2(NREQ);
  localparam int WORD_W = 32;

  localparam logic [IDW-1:0] ID_PC  = 2'd0;
  localparam logic [IDW-1:0] ID_BR  = 2'd1;
  localparam logic [IDW-1:0] ID_MEM = 2'd2;
  localparam logic [IDW-1:0] ID_ALU = 2'd3;
endpackage

// File: rtl/ADDER.sv
// Existing 32-bit combinational adder of the MIPS core.
module ADDER (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] O
);
  assign O = A + B;
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter; search starts one past the last granted id and wraps.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic                     advance,
  output logic [NREQ-1:0]          grant,
  output logic [$clog2(NREQ)-1:0]  grant_id
);
  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] last;
  int             idx;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    idx      = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (req[idx]) begin
        grant         = '0;
        grant[idx]    = 1'b1;
        grant_id      = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last <= IDW'(NREQ - 1);
    else if (advance) last <= grant_id;
  end
endmodule

// File: rtl/adder_arbiter.sv
// Shares the core ADDER among NREQ requesters: round-robin accept stage,
// registered operands, registered sum tagged with the requester id.
module adder_arbiter #(
  parameter int NREQ = mips_pkg::NREQ,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               stall,
  input  logic [NREQ-1:0]                    req_valid,
  input  logic [NREQ*mips_pkg::WORD_W-1:0]   req_a,
  input  logic [NREQ*mips_pkg::WORD_W-1:0]   req_b,
  output logic [NREQ-1:0]                    req_ready,
  output logic [NREQ-1:0]                    resp_valid,
  output logic [IDW-1:0]                     resp_id,
  output logic [mips_pkg::WORD_W-1:0]        resp_sum,
  output logic                               resp_ovf,
  output logic                               busy
);
  localparam int W = mips_pkg::WORD_W;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            xfer;
  logic            op_v;
  logic [W-1:0]    op_a, op_b, sum;
  logic [IDW-1:0]  op_id;

  // Grant is masked during reset so nothing leaks out combinationally.
  assign xfer      = rst_n & ~stall & (|req_valid);
  assign req_ready = xfer ? grant : '0;
  assign busy      = op_v;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid),
    .advance  (xfer),
    .grant    (grant),
    .grant_id (grant_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_v  <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      op_id <= '0;
    end else if (!stall) begin
      op_v <= xfer;
      if (xfer) begin
        op_a  <= req_a[int'(grant_id)*W +: W];
        op_b  <= req_b[int'(grant_id)*W +: W];
        op_id <= grant_id;
      end
    end
  end

  ADDER u_add (
    .A (op_a),
    .B (op_b),
    .O (sum)
  );

  // A stalled op stays in the operand stage and is emitted on the first free edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= '0;
      resp_id    <= '0;
      resp_sum   <= '0;
      resp_ovf   <= 1'b0;
    end else if (stall) begin
      resp_valid <= '0;
    end else begin
      resp_valid <= op_v ? (NREQ'(1) << op_id) : '0;
      resp_id    <= op_id;
      resp_sum   <= sum;
      resp_ovf   <= (op_a[W-1] == op_b[W-1]) && (sum[W-1] != op_a[W-1]);
    end
  end
endmodule
